// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared types and LFSR tap constants for the p-bit node
package pbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_STOCH  = 2'b00,
        MODE_CLAMP0 = 2'b01,
        MODE_CLAMP1 = 2'b10,
        MODE_DET    = 2'b11
    } mode_t;

    // Right-shifting Galois masks; 16 bits is x^16+x^14+x^13+x^11+1
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return {56'd0, LFSR_TAPS_8};
            32:      return {32'd0, LFSR_TAPS_32};
            default: return {48'd0, LFSR_TAPS_16};
        endcase
    endfunction

endpackage

// File: rtl/pbit_lfsr.sv
// rtl/pbit_lfsr.sv - Galois LFSR random source, one step per advance
module pbit_lfsr
    import pbit_pkg::*;
#(
    parameter int           L    = 16,
    parameter logic [L-1:0] SEED = L'(16'hACE1),
    parameter logic [L-1:0] TAPS = L'(LFSR_TAPS_16)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [L-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/pbit_node.sv
// rtl/pbit_node.sv - probabilistic bit: serial local-field accumulate then sigmoid-like sample
module pbit_node
    import pbit_pkg::*;
#(
    parameter int           N_NEIGH = 4,
    parameter int           W_WIDTH = 16,
    parameter int           F       = 8,
    parameter int           L       = 16,
    parameter logic [L-1:0] SEED    = L'(16'hACE1),
    localparam int          ACC_W   = W_WIDTH + $clog2(N_NEIGH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            start,
    input  logic [N_NEIGH-1:0]              neighbours,
    input  logic [N_NEIGH*W_WIDTH-1:0]      weights,
    input  logic signed [W_WIDTH-1:0]       bias,
    input  logic [2:0]                      temp_shift,
    input  logic [1:0]                      mode,
    output logic                            node,
    output logic signed [ACC_W-1:0]         field,
    output logic                            busy,
    output logic                            done
);

    localparam int IW = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;
    localparam int PW = ACC_W + L + 2;
    localparam logic signed [PW-1:0] P_HALF = PW'(1) <<< (L - 1);
    localparam logic signed [PW-1:0] P_MAX  = PW'(1) <<< L;
    localparam logic [L:0]           P_FULL = {1'b1, {L{1'b0}}};
    localparam logic [L-1:0]         TAPS   = L'(lfsr_taps(L));

    state_t                       state;
    mode_t                        mode_q;
    logic [IW-1:0]                idx;
    logic [N_NEIGH-1:0]           neigh_q;
    logic [N_NEIGH*W_WIDTH-1:0]   weights_q;
    logic signed [ACC_W-1:0]      acc;
    logic [L-1:0]                 lfsr;

    logic signed [W_WIDTH-1:0]    w_sel;
    logic signed [ACC_W-1:0]      x;
    logic signed [PW-1:0]         p_wide;
    logic [L:0]                   p;
    logic                         sample_node;

    // Probability is centred at 2^(L-1) and scaled so that field 1.0 maps to 2^(L-2)
    always_comb begin
        w_sel       = weights_q[idx*W_WIDTH +: W_WIDTH];
        x           = acc >>> temp_shift;
        p_wide      = (PW'(x) <<< (L - 2 - F)) + P_HALF;
        p           = '0;
        sample_node = 1'b0;
        if (p_wide < 0) begin
            p = '0;
        end else if (p_wide > P_MAX) begin
            p = P_FULL;
        end else begin
            p = p_wide[L:0];
        end
        case (mode_q)
            MODE_STOCH:  sample_node = ({1'b0, lfsr} < p);
            MODE_CLAMP0: sample_node = 1'b0;
            MODE_CLAMP1: sample_node = 1'b1;
            MODE_DET:    sample_node = ~acc[ACC_W-1];
            default:     sample_node = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_STOCH;
            idx       <= '0;
            neigh_q   <= '0;
            weights_q <= '0;
            acc       <= '0;
            node      <= 1'b0;
            field     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && en) begin
                        neigh_q   <= neighbours;
                        weights_q <= weights;
                        mode_q    <= mode_t'(mode);
                        acc       <= ACC_W'(bias);
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!en) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (neigh_q[idx]) begin
                            acc <= acc + ACC_W'(w_sel);
                        end
                        if (idx == IW'(N_NEIGH - 1)) begin
                            state <= ST_SAMPLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (en) begin
                        node  <= sample_node;
                        field <= acc;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    pbit_lfsr #(
        .L    (L),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance ((state == ST_SAMPLE) && en),
        .state   (lfsr)
    );

endmodule

// File: tb/tb_pbit_node.sv
// tb/tb_pbit_node.sv - self-checking bench for pbit_node against a behavioural model
module tb_pbit_node;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int ACC_W = 19;
    localparam int SEED  = 'hACE1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               start = 1'b0;
    logic [N-1:0]       neighbours = '0;
    logic [N*W-1:0]     weights = '0;
    logic signed [W-1:0] bias = '0;
    logic [2:0]         temp_shift = '0;
    logic [1:0]         mode = '0;
    logic               node;
    logic signed [ACC_W-1:0] field;
    logic               busy;
    logic               done;

    int vectors = 0;
    int fails   = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    pbit_node #(.N_NEIGH(N), .W_WIDTH(W), .F(8), .L(16), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .neighbours (neighbours),
        .weights    (weights),
        .bias       (bias),
        .temp_shift (temp_shift),
        .mode       (mode),
        .node       (node),
        .field      (field),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Behavioural model: an update is a fixed latency followed by a whole-number result
    function automatic int lfsr_step(input int s);
        return (s >> 1) ^ ((s & 1) != 0 ? 'hB400 : 0);
    endfunction

    function automatic int model_acc(input logic [15:0] b, input logic [63:0] w, input logic [3:0] nb);
        int a;
        logic [15:0] wi;
        a = int'($signed(b));
        for (int i = 0; i < N; i++) begin
            wi = w[i*W +: W];
            if (nb[i]) a += int'($signed(wi));
        end
        return a;
    endfunction

    function automatic bit model_node(input int a, input int ts, input int md, input int lf);
        int x;
        longint p;
        x = a >>> ts;
        p = 32768 + longint'(x) * 64;
        if (p < 0) p = 0;
        if (p > 65536) p = 65536;
        case (md)
            0: return (longint'(lf) < p);
            1: return 1'b0;
            2: return 1'b1;
            default: return (a >= 0);
        endcase
    endfunction

    int          m_cnt;
    int          m_lfsr;
    int          m_field;
    bit          m_node;
    bit          m_done;
    logic [15:0] c_bias;
    logic [63:0] c_w;
    logic [3:0]  c_nb;
    logic [1:0]  c_mode;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_lfsr  <= SEED;
            m_field <= 0;
            m_node  <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                if (!en) begin
                    m_cnt <= 0;
                end else if (m_cnt == 1) begin
                    m_cnt   <= 0;
                    m_field <= model_acc(c_bias, c_w, c_nb);
                    m_node  <= model_node(model_acc(c_bias, c_w, c_nb), int'(temp_shift),
                                          int'(c_mode), m_lfsr);
                    m_lfsr  <= lfsr_step(m_lfsr);
                    m_done  <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (start && en) begin
                c_bias <= bias;
                c_w    <= weights;
                c_nb   <= neighbours;
                c_mode <= mode;
                m_cnt  <= N + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy",  busy,  m_cnt > 0);
            check("done",  done,  m_done);
            check("node",  node,  m_node);
            check("field", int'(field), m_field);
        end
    end

    task automatic do_update(input logic [15:0] b, input logic [63:0] w, input logic [3:0] nb,
                             input logic [1:0] md, input logic [2:0] ts, output bit nd);
        int lat;
        bias = b; weights = w; neighbours = nb; mode = md; temp_shift = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N + 1);
        nd = node;
    endtask

    int ones;
    int dones;
    bit nd;
    bit node_before;
    bit exp_seq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_node", node, 0);
        check("rst_field", int'(field), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        en = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        do_update(16'h0000, 64'h0, 4'hF, 2'b11, 3'd0, nd);
        check("det_zero_node", nd, 1);
        check("det_zero_field", int'(field), 0);

        ones = 0;
        for (int i = 0; i < 50; i++) begin
            do_update(16'hFF00, {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 4'b1011, 2'b00, 3'd0, nd);
            ones += nd;
            if (i == 0) check("sat_field", int'(field), 'h600);
        end
        check("sat_ones", ones, 50);

        ones = 0;
        for (int i = 0; i < 100; i++) begin
            do_update(16'h8000, 64'h0, 4'hF, 2'b00, 3'd0, nd);
            ones += nd;
        end
        check("neg_ones", ones, 0);
        do_update(16'h8000, 64'h0, 4'hF, 2'b10, 3'd0, nd);
        check("clamp1_node", nd, 1);

        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            do_update(16'h0000, 64'h0, 4'hF, 2'b00, 3'd0, nd);
            ones += nd;
        end
        check_range("ones_p050", ones, 440, 560);

        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            do_update(16'h0400, 64'h0, 4'hF, 2'b00, 3'd2, nd);
            ones += nd;
        end
        check_range("ones_p075", ones, 690, 810);

        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            do_update(16'h0400, 64'h0, 4'hF, 2'b00, 3'd3, nd);
            ones += nd;
        end
        check_range("ones_p0625", ones, 565, 685);

        // start held across a whole update must yield exactly one completion
        bias = 16'h0100; weights = '0; mode = 2'b11; temp_shift = 3'd0; start = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            dones += done;
        end
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            dones += done;
        end
        check("held_start_dones", dones, 1);

        do_update(16'hFF00, 64'h0, 4'hF, 2'b11, 3'd0, nd);
        check("det_neg_node", nd, 0);
        node_before = node;
        bias = 16'h0300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            dones += done;
        end
        check("abort_dones", dones, 0);
        check("abort_node", node, node_before);

        do_update(16'h0300, 64'h0, 4'hF, 2'b11, 3'd0, nd);
        check("pre_rst_field", int'(field), 'h300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_node", node, 0);
        check("mid_rst_field", int'(field), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LFSR restarts from 0xACE1: states ACE1, E270, 7138, 389C
        for (int i = 0; i < 4; i++) begin
            do_update(16'h0000, 64'h0, 4'hF, 2'b00, 3'd0, nd);
            check("seed_seq", nd, exp_seq[i]);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
